// File: rtl/seg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl_if
// Description : Write port, display outputs and frame tick of the scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [2:0]            wr_idx;
  logic [3:0]            wr_data;
  logic                  lz_blank;
  logic [3:0]            dec_val;
  logic [NUM_DIGITS-1:0] dig_en;
  logic                  frame_tick;

  // master: the producer of digit values and the observer of the display.
  modport master (
    output wr_valid, wr_idx, wr_data, lz_blank,
    input  wr_ready, dec_val, dig_en, frame_tick
  );

  // slave: the scan controller itself.
  modport slave (
    input  wr_valid, wr_idx, wr_data, lz_blank,
    output wr_ready, dec_val, dig_en, frame_tick
  );
endinterface
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Time-multiplexed 7-segment scan controller with double-buffered
//               digit store and optional leading-zero suppression.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 1000,
  parameter int BLANK      = 8
) (
  input  logic            clk,
  input  logic            rst,
  seg_scan_ctrl_if.slave  bus
);

  localparam int c_max   = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int c_cnt_w = (c_max < 2) ? 1 : $clog2(c_max);

  localparam logic [c_cnt_w-1:0] c_dwell_last = c_cnt_w'(DWELL - 1);
  localparam logic [c_cnt_w-1:0] c_blank_last = c_cnt_w'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [2:0]         c_last_digit = 3'(NUM_DIGITS - 1);

  localparam logic [1:0] c_st_blank  = 2'd0;
  localparam logic [1:0] c_st_show   = 2'd1;
  localparam logic [1:0] c_st_commit = 2'd2;
  localparam logic [1:0] c_st_start  = (BLANK == 0) ? c_st_show : c_st_blank;

  // State/digit/counter describe the cycle that the output registers load next.
  logic [1:0]         r_state, w_state_nxt;
  logic [2:0]         r_digit, w_digit_nxt;
  logic [c_cnt_w-1:0] r_cnt,   w_cnt_nxt;

  logic [3:0] r_shadow [NUM_DIGITS];
  logic [3:0] r_active [NUM_DIGITS];
  logic [3:0] w_src    [NUM_DIGITS];

  logic [NUM_DIGITS-1:0] r_dig_en, w_dig_en;
  logic [3:0]            r_dec_val, w_dec_val, w_sel, w_disp;
  logic                  r_frame_tick, w_frame_tick;
  logic                  r_wr_ready, w_wr_ready;
  logic                  w_load, w_upper_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_start;
      r_digit <= 3'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_digit <= w_digit_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_digit_nxt = r_digit;
    w_cnt_nxt   = r_cnt + 1'b1;
    case (r_state)
      c_st_blank: begin
        if (r_cnt == c_blank_last) begin
          w_state_nxt = c_st_show;
          w_cnt_nxt   = '0;
        end
      end
      c_st_show: begin
        if (r_cnt == c_dwell_last) begin
          w_cnt_nxt = '0;
          if (r_digit == c_last_digit) begin
            w_state_nxt = c_st_commit;
          end else begin
            w_state_nxt = c_st_start;
            w_digit_nxt = r_digit + 3'd1;
          end
        end
      end
      c_st_commit: begin
        w_state_nxt = c_st_start;
        w_digit_nxt = 3'd0;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = c_st_start;
        w_digit_nxt = 3'd0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // On the edge that leaves COMMIT, active is still being loaded, so the
  // first digit of the new frame reads the shadow copy directly.
  always_comb begin
    w_upper_zero = 1'b1;
    w_sel        = 4'h0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_src[k] = r_frame_tick ? r_shadow[k] : r_active[k];
      if ((3'(k) >= r_digit) && (w_src[k] != 4'h0)) w_upper_zero = 1'b0;
      if (3'(k) == r_digit) w_sel = w_src[k];
    end
    w_disp = (bus.lz_blank && (r_digit != 3'd0) && w_upper_zero) ? 4'hF : w_sel;
  end

  always_comb begin
    w_dig_en     = '0;
    w_wr_ready   = 1'b1;
    w_frame_tick = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      c_st_blank:  w_load = (r_cnt == '0);
      c_st_show: begin
        w_dig_en = NUM_DIGITS'(1) << r_digit;
        w_load   = (BLANK == 0) && (r_cnt == '0);
      end
      c_st_commit: begin
        w_wr_ready   = 1'b0;
        w_frame_tick = 1'b1;
      end
      default: w_wr_ready = 1'b1;
    endcase
    if (r_state == c_st_commit) w_dec_val = 4'hF;
    else if (w_load)            w_dec_val = w_disp;
    else                        w_dec_val = r_dec_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dig_en     <= '0;
      r_dec_val    <= 4'hF;
      r_frame_tick <= 1'b0;
      r_wr_ready   <= 1'b0;
    end else begin
      r_dig_en     <= w_dig_en;
      r_dec_val    <= w_dec_val;
      r_frame_tick <= w_frame_tick;
      r_wr_ready   <= w_wr_ready;
    end
  end

  // wr_ready is low throughout the commit cycle, so copy and write never collide.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (rst) begin
        r_shadow[k] <= 4'h0;
        r_active[k] <= 4'h0;
      end else begin
        if (bus.wr_valid && r_wr_ready && (bus.wr_idx == 3'(k))) r_shadow[k] <= bus.wr_data;
        if (r_frame_tick) r_active[k] <= r_shadow[k];
      end
    end
  end

  assign bus.dig_en     = r_dig_en;
  assign bus.dec_val    = r_dec_val;
  assign bus.frame_tick = r_frame_tick;
  assign bus.wr_ready   = r_wr_ready;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_ctrl
// Description : Self-checking bench for seg_scan_ctrl (two parameter sets).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

  typedef logic [3:0] digs_t [4];

  localparam int c_bl [2] = '{2, 0};
  localparam int c_dw [2] = '{4, 1};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic [2:0] wr_idx = 3'd0;
  logic [3:0] wr_data = 4'd0;
  logic       lz_blank = 1'b0;

  always #5 clk = ~clk;

  seg_scan_ctrl_if #(.NUM_DIGITS(4)) bus_a ();
  seg_scan_ctrl_if #(.NUM_DIGITS(4)) bus_b ();

  assign bus_a.wr_valid = wr_valid;
  assign bus_a.wr_idx   = wr_idx;
  assign bus_a.wr_data  = wr_data;
  assign bus_a.lz_blank = lz_blank;
  assign bus_b.wr_valid = wr_valid;
  assign bus_b.wr_idx   = wr_idx;
  assign bus_b.wr_data  = wr_data;
  assign bus_b.lz_blank = lz_blank;

  seg_scan_ctrl #(.NUM_DIGITS(4), .DWELL(4), .BLANK(2)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  seg_scan_ctrl #(.NUM_DIGITS(4), .DWELL(1), .BLANK(0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: position in frame is plain modular arithmetic on the
  // cycle count since reset release.
  int         m_t   [2];
  digs_t      m_sh  [2];
  digs_t      m_ac  [2];
  logic [3:0] m_en  [2];
  logic [3:0] m_dec [2];
  logic       m_tick[2] = '{1'b0, 1'b0};
  logic       m_rdy [2] = '{1'b0, 1'b0};
  int         m_dig [2];
  bit         m_lit [2];
  bit         m_acc;

  function automatic logic [3:0] mdisp(input int d, input digs_t a, input bit lz);
    bit zero = 1'b1;
    for (int k = d; k < 4; k++) if (a[k] != 4'h0) zero = 1'b0;
    if (lz && d > 0 && zero) return 4'hF;
    return a[d];
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    bit         rv = rst;
    bit         v  = wr_valid;
    logic [2:0] ix = wr_idx;
    logic [3:0] dt = wr_data;
    bit         lz = lz_blank;
    int         fr, p, d, off;
    @(posedge clk);
    #1;
    m_acc = v && m_rdy[0];
    for (int u = 0; u < 2; u++) begin
      m_lit[u] = 1'b0;
      if (rv) begin
        m_t[u] = -1;
        for (int k = 0; k < 4; k++) begin
          m_sh[u][k] = 4'h0;
          m_ac[u][k] = 4'h0;
        end
        m_en[u] = 4'h0; m_dec[u] = 4'hF; m_tick[u] = 1'b0; m_rdy[u] = 1'b0;
      end else begin
        if (m_tick[u]) m_ac[u] = m_sh[u];
        if (v && m_rdy[u] && ix < 3'd4) m_sh[u][ix] = dt;
        m_t[u]++;
        fr = 4 * (c_bl[u] + c_dw[u]) + 1;
        p  = m_t[u] % fr;
        if (p == fr - 1) begin
          m_en[u] = 4'h0; m_dec[u] = 4'hF; m_tick[u] = 1'b1; m_rdy[u] = 1'b0;
        end else begin
          d   = p / (c_bl[u] + c_dw[u]);
          off = p % (c_bl[u] + c_dw[u]);
          m_lit[u] = (off >= c_bl[u]);
          m_dig[u] = d;
          m_en[u]  = m_lit[u] ? 4'(1 << d) : 4'h0;
          if (off == 0) m_dec[u] = mdisp(d, m_ac[u], lz);
          m_tick[u] = 1'b0; m_rdy[u] = 1'b1;
        end
      end
    end
    check("a.dig_en",     8'(bus_a.dig_en),     8'(m_en[0]));
    check("a.dec_val",    8'(bus_a.dec_val),    8'(m_dec[0]));
    check("a.frame_tick", 8'(bus_a.frame_tick), 8'(m_tick[0]));
    check("a.wr_ready",   8'(bus_a.wr_ready),   8'(m_rdy[0]));
    check("b.dig_en",     8'(bus_b.dig_en),     8'(m_en[1]));
    check("b.dec_val",    8'(bus_b.dec_val),    8'(m_dec[1]));
    check("b.frame_tick", 8'(bus_b.frame_tick), 8'(m_tick[1]));
    check("b.wr_ready",   8'(bus_b.wr_ready),   8'(m_rdy[1]));
  endtask

  task automatic timeout(input string tag);
    n_assert++;
    n_fail++;
    $error("FAIL %s: observed timeout, expected event", tag);
  endtask

  // Holds a write valid until unit A accepts it.
  task automatic wr(input logic [2:0] idx, input logic [3:0] data);
    bit done = 1'b0;
    wr_valid = 1'b1; wr_idx = idx; wr_data = data;
    for (int i = 0; i < 8 && !done; i++) begin
      tick();
      done = m_acc;
    end
    wr_valid = 1'b0;
    if (!done) timeout("write_accept");
  endtask

  task automatic wait_lit(input int d);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (m_lit[0] && m_dig[0] == d) done = 1'b1;
      else tick();
    end
    if (!done) timeout("wait_show");
  endtask

  task automatic wait_commit();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (m_tick[0]) done = 1'b1;
      else tick();
    end
    if (!done) timeout("wait_commit");
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (60) tick();

    wait_lit(1);
    wr(3'd0, 4'd1); wr(3'd1, 4'd2); wr(3'd2, 4'd3); wr(3'd3, 4'd4);
    repeat (60) tick();

    wait_commit();
    wr(3'd2, 4'd9);
    repeat (30) tick();

    wr(3'd0, 4'd0); wr(3'd1, 4'd5); wr(3'd2, 4'd0); wr(3'd3, 4'd0);
    lz_blank = 1'b1;
    repeat (60) tick();
    wr(3'd1, 4'd0);
    repeat (60) tick();
    wr(3'd1, 4'd5);
    lz_blank = 1'b0;
    repeat (60) tick();

    wr(3'd6, 4'd7); wr(3'd1, 4'hC);
    repeat (60) tick();

    repeat (600) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_idx   = 3'($urandom_range(0, 7));
      wr_data  = 4'($urandom);
      if ($urandom_range(0, 19) == 0) lz_blank = ~lz_blank;
      tick();
    end
    wr_valid = 1'b0;
    lz_blank = 1'b0;

    repeat (40) tick();
    wait_lit(1);
    wr(3'd3, 4'd8); wr(3'd0, 4'd6);
    wait_lit(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (60) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller that shares one combinational 4-bit-to-7-segment decoder among NUM_DIGITS common-enable digits. It holds a double-buffered digit store written through a valid/ready port, and sequences blank/show intervals per digit. It also drives the decoder input and the one-hot digit enables, and optionally suppresses leading zeros. It sits between the counter/datapath logic that produces BCD values and the decoder/pad outputs.

## Interface
- NUM_DIGITS, 4: digits scanned, legal 2..8; digit 0 is least significant.
- DWELL, 1000: cycles each digit is enabled, legal ≥1.
- BLANK, 8: dead cycles before each digit (anti-ghosting), legal ≥0.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_valid  input  1  write request into shadow store.
- wr_ready  output  1  write accepted when wr_valid && wr_ready at clock edge.
- wr_idx  input  3  target digit index.
- wr_data  input  4  digit value; 0-9 display, A-F display blank.
- lz_blank  input  1  1 = suppress leading zeros.
- dec_val  output  4  value to shared decoder; 4'hF = blank.
- dig_en  output  NUM_DIGITS  one-hot active-high digit enable, all-zero when no digit is lit.
- frame_tick  output  1  one-cycle pulse in the commit cycle.

## Operation
- Two stores of NUM_DIGITS x 4 bits: shadow (written by port) and active (displayed).
- Write: on accepted handshake, shadow[wr_idx] <= wr_data. wr_idx ≥ NUM_DIGITS is accepted and has no effect. Values >9 are stored unchanged.
- FSM states: BLANK, SHOW, COMMIT. Digit index d, 0..NUM_DIGITS-1. Cycle counter sized for max(DWELL, BLANK).
- BLANK(d): dig_en=0, dec_val=disp(d); lasts BLANK cycles. If BLANK=0, skip directly to SHOW(d).
- SHOW(d): dig_en = 1<<d, dec_val=disp(d); lasts DWELL cycles. Then go to BLANK(d+1), or to COMMIT if d=NUM_DIGITS-1.
- COMMIT: one cycle. active <= shadow (all digits at once), frame_tick=1, wr_ready=0, dig_en=0, dec_val=F. Then BLANK(0).
- wr_ready=1 in all other states, 0 while rst is high. No write can coincide with commit, so commit always copies a consistent snapshot.
- disp(d): active[d], except when lz_blank=1, d>0, and active[d..NUM_DIGITS-1] are all zero: then 4'hF. Digit 0 is never blanked by lz_blank.
- disp(d) and lz_blank are evaluated on entry to BLANK(d), or on entry to SHOW(d) when BLANK=0. dec_val holds that value through SHOW(d).
- Reset mid-frame: abort immediately. The next cycle is the reset state with no commit, and shadow and active are cleared.

## Timing
- All outputs registered. Reset values: dig_en=0, dec_val=4'hF, frame_tick=0, wr_ready=0; shadow=active=0; state=BLANK, d=0, counter=0.
- First cycle after rst falls: wr_ready=1, BLANK(0) begins.
- Frame length: NUM_DIGITS*(BLANK+DWELL)+1 cycles; frame_tick period equals the frame length.
- Write-to-display latency: a write is visible at the first SHOW after the next COMMIT.
  - Minimum: remainder of the current frame + 1.
  - Maximum: one full frame + 1.
- dec_val is stable ≥BLANK cycles before dig_en rises, and remains stable in the cycle dig_en falls.
- dig_en never has more than one bit set; there is no cycle with two digits lit.

## Test plan
- Reset/idle, NUM_DIGITS=4, DWELL=4, BLANK=2: hold rst 3 cycles.
  - During reset: dig_en=0, dec_val=F, wr_ready=0.
  - After release: frame_tick pulses every 25 cycles; dig_en sequence 0001, 0010, 0100, 1000, each 4 cycles with 2 zero cycles before; all dec_val=0.
- Write and commit: write idx0..3 = 1,2,3,4 mid-frame.
  - Current frame still shows 0s.
  - After frame_tick, the next frame shows dec_val 1,2,3,4 with dig_en bits 0..3.
  - wr_ready=0 exactly in the frame_tick cycle; a write held valid over that cycle completes the following cycle.
- Leading-zero blanking: active = {0,0,5,0} (idx3..0), lz_blank=1.
  - dec_val = 0,5,F,F for digits 0..3.
  - With active all zero: 0,F,F,F.
  - With lz_blank=0: 0,5,0,0.
- Out-of-range and invalid data: write idx=6 data=7, then idx1=4'hC. After commit, all digits except 1 are unchanged, and digit 1 shows dec_val=C.
- BLANK=0, DWELL=1: dig_en walks 0001, 0010, 0100, 1000, 0000 (commit); frame = 5 cycles; dec_val changes in the same edge as dig_en.
- Reset mid-operation: assert rst during SHOW(2) with pending shadow writes.
  - Next cycle: all outputs are at reset values.
  - After release: frame restarts at BLANK(0) and displays zeros; pending writes are lost.
